// File: rtl/axi_sram_arbiter.sv
// Two-master to one-slave AXI4-lite arbiter in front of the SRAM; single outstanding, single beat.
// Define ARB_FIXED_PRIO_EN for fixed priority (LSU wins ties); default is round-robin.
module axi_sram_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          m_arvalid,
    output logic [1:0]          m_arready,
    input  logic [2*AW-1:0]     m_araddr,
    output logic [1:0]          m_rvalid,
    input  logic [1:0]          m_rready,
    output logic [DW-1:0]       m_rdata,
    output logic [1:0]          m_rresp,
    input  logic [1:0]          m_awvalid,
    output logic [1:0]          m_awready,
    input  logic [2*AW-1:0]     m_awaddr,
    input  logic [1:0]          m_wvalid,
    output logic [1:0]          m_wready,
    input  logic [2*DW-1:0]     m_wdata,
    input  logic [2*DW/8-1:0]   m_wstrb,
    output logic [1:0]          m_bvalid,
    input  logic [1:0]          m_bready,
    output logic [1:0]          m_bresp,
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [AW-1:0]       s_araddr,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DW-1:0]       s_rdata,
    input  logic [1:0]          s_rresp,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [AW-1:0]       s_awaddr,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DW-1:0]       s_wdata,
    output logic [DW/8-1:0]     s_wstrb,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [1:0]          s_bresp
);

    localparam int unsigned SW = DW / 8;

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B} state_t;

    state_t state_q, state_d;
    logic   g_q, g_d;
    logic   last_q, last_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic [1:0] pending;
    logic   tie_pick;
    logic   g_sel;
    logic   aw_fin;
    logic   w_fin;

    // A write only requests once both its address and data are offered
    assign pending = m_arvalid | (m_awvalid & m_wvalid);

`ifdef ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b1;
`else
    assign tie_pick = ~last_q;
`endif

    assign g_sel  = (&pending) ? tie_pick : pending[1];
    assign aw_fin = aw_done_q | s_awready;
    assign w_fin  = w_done_q | s_wready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            g_q       <= 1'b0;
            last_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        last_d    = last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        m_arready = 2'b00;
        m_rvalid  = 2'b00;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_awready = 2'b00;
        m_wready  = 2'b00;
        m_bvalid  = 2'b00;
        m_bresp   = 2'b00;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_rready  = 1'b0;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_bready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|pending) begin
                    g_d     = g_sel;
                    state_d = m_arvalid[g_sel] ? RD_A : WR_A;
                end
            end
            RD_A: begin
                s_arvalid      = 1'b1;
                s_araddr       = g_q ? m_araddr[2*AW-1:AW] : m_araddr[AW-1:0];
                m_arready[g_q] = s_arready;
                if (s_arready) state_d = RD_D;
            end
            RD_D: begin
                m_rvalid[g_q] = s_rvalid;
                s_rready      = m_rready[g_q];
                m_rdata       = s_rdata;
                m_rresp       = s_rresp;
                if (s_rvalid && m_rready[g_q]) begin
                    state_d = IDLE;
                    last_d  = g_q;
                end
            end
            WR_A: begin
                s_awvalid      = ~aw_done_q;
                s_wvalid       = ~w_done_q;
                s_awaddr       = g_q ? m_awaddr[2*AW-1:AW] : m_awaddr[AW-1:0];
                s_wdata        = g_q ? m_wdata[2*DW-1:DW] : m_wdata[DW-1:0];
                s_wstrb        = g_q ? m_wstrb[2*SW-1:SW] : m_wstrb[SW-1:0];
                m_awready[g_q] = s_awready & ~aw_done_q;
                m_wready[g_q]  = s_wready & ~w_done_q;
                // AW and W may finish in either order or together
                if (aw_fin && w_fin) begin
                    state_d   = WR_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            WR_B: begin
                m_bvalid[g_q] = s_bvalid;
                s_bready      = m_bready[g_q];
                m_bresp       = s_bresp;
                if (s_bvalid && m_bready[g_q]) begin
                    state_d = IDLE;
                    last_d  = g_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_sram_arbiter.sv
// Directed bench for axi_sram_arbiter: read vector table plus hand-written write/reset sequences.
module tb_axi_sram_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready, m_rresp;
    logic [63:0] m_araddr, m_awaddr, m_wdata;
    logic [31:0] m_rdata;
    logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready, m_bresp;
    logic [7:0]  m_wstrb;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic        s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [1:0]  s_rresp, s_bresp;
    logic [3:0]  s_wstrb;

    int nvec = 0;
    int nerr = 0;

    axi_sram_arbiter #(.AW(32), .DW(32)) dut (
        .clock(clock), .reset(reset),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [50:0] all_out;
    logic [14:0] vr_out;
    logic [8:0]  wr_out;
    assign all_out = {m_arready, m_rvalid, m_rdata, m_rresp, m_awready, m_wready, m_bvalid,
                      m_bresp, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
    assign vr_out  = {m_arready, m_awready, m_wready, s_arvalid, s_awvalid, s_wvalid,
                      s_rready, s_bready, m_rvalid, m_bvalid};
    assign wr_out  = {m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready};

    typedef struct {
        logic        rst;
        logic [1:0]  arv;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        sar;
        logic        srv;
        logic [31:0] sd;
        logic [1:0]  rrdy;
        logic [1:0]  e_arr;
        logic [1:0]  e_rv;
        logic        e_sarv;
        logic        e_srr;
        logic [31:0] e_sa;
        logic [31:0] e_rd;
    } rd_vec_t;

    localparam int NV = 21;
    rd_vec_t vt [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in();
        m_arvalid = 2'b00; m_araddr = 64'h0; m_rready = 2'b00;
        m_awvalid = 2'b00; m_awaddr = 64'h0; m_wvalid = 2'b00;
        m_wdata = 64'h0; m_wstrb = 8'h00; m_bready = 2'b00;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clr_in();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // rows 0-3: single IFU read with a 1-cycle slave
        vt[0]  = '{1'b1, 2'b01, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0};
        vt[1]  = '{1'b0, 2'b01, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 32'h0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 32'h8000_0000, 32'h0};
        vt[2]  = '{1'b0, 2'b00, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 32'h0, 32'h1234_5678};
        vt[3]  = '{1'b0, 2'b00, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0};
        // rows 4-12: both masters reading continuously, round-robin 0,1,0
        vt[4]  = '{1'b1, 2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hAAAA_0000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0};
        vt[5]  = '{1'b0, 2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hAAAA_0000, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0};
        vt[6]  = '{1'b0, 2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hAAAA_0001, 2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 32'h0, 32'hAAAA_0001};
        vt[7]  = '{1'b0, 2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hAAAA_0000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0};
        vt[8]  = '{1'b0, 2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hAAAA_0000, 2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 32'h200, 32'h0};
        vt[9]  = '{1'b0, 2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hAAAA_0002, 2'b11, 2'b00, 2'b10, 1'b0, 1'b1, 32'h0, 32'hAAAA_0002};
        vt[10] = '{1'b0, 2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hAAAA_0000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0};
        vt[11] = '{1'b0, 2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hAAAA_0000, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0};
        vt[12] = '{1'b0, 2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hAAAA_0003, 2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 32'h0, 32'hAAAA_0003};
        // rows 13-20: LSU read stalled by rready, IFU waits in IDLE
        vt[13] = '{1'b1, 2'b10, 32'h400, 32'h300, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0};
        vt[14] = '{1'b0, 2'b10, 32'h400, 32'h300, 1'b1, 1'b0, 32'h0, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 32'h300, 32'h0};
        vt[15] = '{1'b0, 2'b01, 32'h400, 32'h300, 1'b0, 1'b1, 32'h5555_AAAA, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0, 32'h5555_AAAA};
        vt[16] = vt[15];
        vt[17] = vt[15];
        vt[18] = '{1'b0, 2'b01, 32'h400, 32'h300, 1'b0, 1'b1, 32'h5555_AAAA, 2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 32'h0, 32'h5555_AAAA};
        vt[19] = '{1'b0, 2'b01, 32'h400, 32'h300, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0};
        vt[20] = '{1'b0, 2'b01, 32'h400, 32'h300, 1'b1, 1'b0, 32'h0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 32'h400, 32'h0};

        // outputs while held in reset, slave inputs deliberately busy
        reset = 1'b0;
        clr_in();
        s_rvalid = 1'b1; s_rdata = 32'hFFFF_FFFF; s_rresp = 2'b11; s_bvalid = 1'b1;
        s_bresp = 2'b11; s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        m_arvalid = 2'b11; m_rready = 2'b11; m_bready = 2'b11;
        #2;
        chk("reset_outputs", 64'(all_out), 64'h0);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].rst) do_reset();
            m_arvalid = vt[i].arv;
            m_araddr  = {vt[i].a1, vt[i].a0};
            s_arready = vt[i].sar;
            s_rvalid  = vt[i].srv;
            s_rdata   = vt[i].sd;
            m_rready  = vt[i].rrdy;
            #4;
            chk($sformatf("row%0d m_arready", i), 64'(m_arready), 64'(vt[i].e_arr));
            chk($sformatf("row%0d m_rvalid", i), 64'(m_rvalid), 64'(vt[i].e_rv));
            chk($sformatf("row%0d s_arvalid", i), 64'(s_arvalid), 64'(vt[i].e_sarv));
            chk($sformatf("row%0d s_rready", i), 64'(s_rready), 64'(vt[i].e_srr));
            chk($sformatf("row%0d s_araddr", i), 64'(s_araddr), 64'(vt[i].e_sa));
            chk($sformatf("row%0d m_rdata", i), 64'(m_rdata), 64'(vt[i].e_rd));
            chk($sformatf("row%0d write_side", i), 64'(wr_out), 64'h0);
            tick();
        end

        // LSU write: wready first, awready two cycles later
        do_reset();
        m_awvalid = 2'b10; m_wvalid = 2'b10; m_bready = 2'b10;
        m_awaddr = {32'h8000_0010, 32'h0}; m_wdata = {32'hDEAD_BEEF, 32'h0}; m_wstrb = 8'h30;
        #4;
        chk("wr idle_ready", 64'({m_awready, m_wready, s_awvalid}), 64'h0);
        tick();
        s_wready = 1'b1;
        #4;
        chk("wr c1 valids", 64'({s_awvalid, s_wvalid}), 64'h3);
        chk("wr c1 awaddr", 64'(s_awaddr), 64'h8000_0010);
        chk("wr c1 wdata", 64'(s_wdata), 64'hDEAD_BEEF);
        chk("wr c1 wstrb", 64'(s_wstrb), 64'h3);
        chk("wr c1 readies", 64'({m_awready, m_wready}), 64'b0010);
        tick();
        m_wvalid = 2'b00;
        #4;
        chk("wr c2 valids", 64'({s_awvalid, s_wvalid}), 64'b10);
        chk("wr c2 readies", 64'({m_awready, m_wready}), 64'h0);
        tick();
        s_awready = 1'b1;
        #4;
        chk("wr c3 awready", 64'({m_awready, m_wready}), 64'b1000);
        chk("wr c3 valids", 64'({s_awvalid, s_wvalid}), 64'b10);
        tick();
        m_awvalid = 2'b00; s_bvalid = 1'b1; s_bresp = 2'b00;
        #4;
        chk("wr c4 no_extra_aw", 64'({s_awvalid, s_wvalid, m_awready, m_wready}), 64'h0);
        chk("wr c4 bvalid", 64'(m_bvalid), 64'b10);
        chk("wr c4 bready", 64'(s_bready), 64'h1);
        chk("wr c4 bresp", 64'(m_bresp), 64'h0);
        tick();
        s_bvalid = 1'b0;
        #4;
        chk("wr c5 idle", 64'(all_out), 64'h0);

        // LSU read and write together: read first, one IDLE cycle, then write
        do_reset();
        m_arvalid = 2'b10; m_awvalid = 2'b10; m_wvalid = 2'b10;
        m_araddr = {32'h600, 32'h0}; m_awaddr = {32'h700, 32'h0};
        m_rready = 2'b10; m_bready = 2'b10;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        #4;
        chk("rw c0 idle", 64'({s_arvalid, s_awvalid}), 64'h0);
        tick();
        #4;
        chk("rw c1 ar", 64'({s_arvalid, s_awvalid, m_arready}), 64'b1010);
        chk("rw c1 araddr", 64'(s_araddr), 64'h600);
        tick();
        m_arvalid = 2'b00; s_rvalid = 1'b1; s_rdata = 32'hCAFE_0001; s_rresp = 2'b01;
        #4;
        chk("rw c2 rvalid", 64'({m_rvalid, s_awvalid}), 64'b100);
        chk("rw c2 rdata", 64'(m_rdata), 64'hCAFE_0001);
        chk("rw c2 rresp", 64'(m_rresp), 64'h1);
        tick();
        s_rvalid = 1'b0;
        #4;
        chk("rw c3 idle", 64'(all_out), 64'h0);
        tick();
        #4;
        chk("rw c4 aw", 64'({s_awvalid, s_wvalid, m_awready, m_wready}), 64'b111010);
        chk("rw c4 awaddr", 64'(s_awaddr), 64'h700);
        tick();
        m_awvalid = 2'b00; m_wvalid = 2'b00; s_bvalid = 1'b1; s_bresp = 2'b10;
        #4;
        chk("rw c5 b", 64'({m_bvalid, m_bresp, s_awvalid}), 64'b10100);
        tick();
        s_bvalid = 1'b0;
        #4;
        chk("rw c6 idle", 64'(all_out), 64'h0);

        // asynchronous reset while in WR_A
        do_reset();
        m_awvalid = 2'b01; m_wvalid = 2'b01; m_awaddr = {32'h0, 32'h900};
        #4;
        tick();
        #4;
        chk("rst c1 valids", 64'({s_awvalid, s_wvalid}), 64'b11);
        s_awready = 1'b1; s_wready = 1'b1;
        #1;
        chk("rst pre readies", 64'({m_awready, m_wready}), 64'b0101);
        reset = 1'b0;
        #1;
        chk("rst async_zero", 64'(vr_out), 64'h0);
        s_awready = 1'b0; s_wready = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #4;
        chk("rst released_idle", 64'(vr_out), 64'h0);
        tick();
        #4;
        chk("rst regrant_flags_clear", 64'({s_awvalid, s_wvalid, s_awaddr}), 64'({2'b11, 32'h900}));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/axi_sram_arbiter.md
Name: axi_sram_arbiter

Overview:
- 2-master to 1-slave AXI4-lite-style arbiter in front of the SRAM slave.
- Master 0 is IFU (reads only in practice; the write channel is tied off). Master 1 is LSU (reads and writes).
- Single outstanding transaction, single-beat only. The slave's burst/id/size/last signals are driven as constants at the top level, outside this block.
- Grants are round-robin. Read and write to the slave are never concurrent.

Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m_arvalid  in  2  per-master read-address valid, bit i = master i
- m_arready  out  2  per-master read-address ready
- m_araddr  in  2*AW  packed read addresses, [AW*i +: AW] = master i
- m_rvalid  out  2  per-master read-data valid
- m_rready  in  2  per-master read-data ready
- m_rdata  out  DW  read data, broadcast to both masters
- m_rresp  out  2  read response, broadcast
- m_awvalid  in  2  per-master write-address valid
- m_awready  out  2  per-master write-address ready
- m_awaddr  in  2*AW  packed write addresses
- m_wvalid  in  2  per-master write-data valid
- m_wready  out  2  per-master write-data ready
- m_wdata  in  2*DW  packed write data
- m_wstrb  in  2*DW/8  packed write strobes
- m_bvalid  out  2  per-master write-response valid
- m_bready  in  2  per-master write-response ready
- m_bresp  out  2  write response, broadcast
- s_arvalid/s_arready/s_araddr  out/in/out  1/1/AW  slave read-address channel
- s_rvalid/s_rready/s_rdata/s_rresp  in/out/in/in  1/1/DW/2  slave read-data channel
- s_awvalid/s_awready/s_awaddr  out/in/out  1/1/AW  slave write-address channel
- s_wvalid/s_wready/s_wdata/s_wstrb  out/in/out/out  1/1/DW/DW/8  slave write-data channel
- s_bvalid/s_bready/s_bresp  in/out/in  1/1/2  slave write-response channel

Behaviour:
- FSM states: IDLE, RD_A, RD_D, WR_A, WR_B. Grant register g (1 bit). Priority pointer last (1 bit).
- Reset (reset=0, asynchronous): state=IDLE, g=0, last=1 (so master 0 wins first), aw_done=w_done=0.
  - Every m_* and s_* valid/ready output is 0. m_rdata, m_rresp, m_bresp are 0.
- Master i is pending when m_arvalid[i] | (m_awvalid[i] & m_wvalid[i]). A lone awvalid or a lone wvalid does not request.
- IDLE:
  - No ready is asserted to any master.
  - If both masters are pending, g = ~last. Otherwise g = the single pending master.
  - Within the granted master, read beats write.
  - Next state is RD_A or WR_A, registered, so there is 1 cycle of arbitration latency.
- RD_A: s_arvalid=1, s_araddr=m_araddr[g], m_arready[g]=s_arready. On s_arready, go to RD_D.
- RD_D:
  - m_rvalid[g]=s_rvalid, s_rready=m_rready[g], m_rdata=s_rdata, m_rresp=s_rresp.
  - On s_rvalid & s_rready: go to IDLE and set last=g.
- WR_A:
  - s_awvalid = ~aw_done; s_wvalid = ~w_done. Address, data and strobes are muxed from g.
  - m_awready[g]=s_awready & ~aw_done; m_wready[g]=s_wready & ~w_done.
  - The AW and W handshakes may complete in the same cycle or in either order; aw_done and w_done latch each one.
  - When both are done (including same-cycle completion): go to WR_B and clear both flags.
- WR_B:
  - m_bvalid[g]=s_bvalid, s_bready=m_bready[g], m_bresp=s_bresp.
  - On handshake: go to IDLE and set last=g.
- Non-granted master: all of its ready and valid outputs are 0 in every state.
- Masters obey AXI valid stability. Dropping valid after a grant is a protocol violation; behaviour in that case is undefined.
- Minimum read: request in cycle 0 → s_arvalid in cycle 1 → with a 1-cycle slave, m_rvalid in cycle 2 → IDLE in cycle 3.
- Back-to-back: IDLE is re-entered for 1 cycle between any two transactions. There is no bypass.
- Reset asserted mid-transaction: the FSM aborts immediately to IDLE. The slave is reset together with the arbiter.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Master 1 (LSU) always wins when both masters are pending, and `last` is not used.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset released; m_arvalid=2'b01, araddr0=0x8000_0000; 1-cycle slave → s_arvalid high in cycle 1 with addr 0x8000_0000; m_rvalid[0] in cycle 2 with slave data 0x1234_5678; m_rvalid[1] stays 0.
- Both masters read at once (addr0=0x100, addr1=0x200), held continuously → first grant goes to master 0, then master 1, then master 0; slave sees the address sequence 0x100, 0x200, 0x100.
- LSU write addr 0x8000_0010, data 0xDEAD_BEEF, wstrb 4'b0011; slave raises awready 2 cycles after wready → single m_awready[1] and m_wready[1] pulses; m_bvalid[1] with bresp 0; no extra s_awvalid.
- LSU with arvalid and awvalid+wvalid asserted together → read is issued first, write after, with exactly one IDLE cycle between them.
- m_rready[1] held low 3 cycles during RD_D → m_rvalid[1] and m_rdata stay stable; master 0's request waits in IDLE until RD_D completes.
- reset pulled low while in WR_A → all s_*valid and m_*ready outputs are 0 immediately; state is IDLE after reset rises.
